// File: rtl/lock_pkg.sv
// Symbol codes shared by the lock FSM and the display scheduler.
package lock_pkg;

  localparam logic [4:0] SYM_C     = 5'h10;
  localparam logic [4:0] SYM_L     = 5'h11;
  localparam logic [4:0] SYM_TIRE  = 5'h12;
  localparam logic [4:0] SYM_BLANK = 5'h1F;

  localparam logic [19:0] CODE_BLANK = {4{SYM_BLANK}};

  // Active-low anode pattern that lights a single digit.
  function automatic logic [3:0] digit_anode(input logic [1:0] idx);
    logic [3:0] onehot;
    onehot = 4'b0001 << idx;
    return ~onehot;
  endfunction

endpackage

// File: rtl/binary_to_segment.sv
// Combinational symbol to seven-segment decoder; output is {g..a}, active-low.
module binary_to_segment
  import lock_pkg::*;
(
  input  logic [4:0] sym,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'b1111111;
    case (sym)
      5'h00:    seg = 7'b1000000;
      5'h01:    seg = 7'b1111001;
      5'h02:    seg = 7'b0100100;
      5'h03:    seg = 7'b0110000;
      5'h04:    seg = 7'b0011001;
      5'h05:    seg = 7'b0010010;
      5'h06:    seg = 7'b0000010;
      5'h07:    seg = 7'b1111000;
      5'h08:    seg = 7'b0000000;
      5'h09:    seg = 7'b0010000;
      5'h0A:    seg = 7'b0001000;
      5'h0B:    seg = 7'b0000011;
      5'h0C:    seg = 7'b1000110;
      5'h0D:    seg = 7'b0100001;
      5'h0E:    seg = 7'b0000110;
      5'h0F:    seg = 7'b0001110;
      SYM_C:    seg = 7'b1000110;
      SYM_L:    seg = 7'b1000111;
      SYM_TIRE: seg = 7'b0111111;
      default:  seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Four-digit seven-segment scan scheduler with per-digit blinking and
// frame-aligned display updates.
module ssd_scan_ctrl
  import lock_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned BLINK_DIV = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] code_in,
  input  logic [3:0]  blink_mask,
  input  logic        code_valid,
  input  logic        blink_sync,
  output logic        disp_updated,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        blink_phase
);

  localparam int unsigned ScanW  = $clog2(SCAN_DIV);
  localparam int unsigned BlinkW = $clog2(BLINK_DIV);

  logic [ScanW-1:0]  scan_cnt;
  logic [BlinkW-1:0] blink_cnt;
  logic [1:0]        digit_idx;
  logic              started;
  logic [19:0]       code_act, code_pend;
  logic [3:0]        mask_act, mask_pend;
  logic              pend_flag;
  logic              scan_tick, frame_start, blink_tc;
  logic [4:0]        sym_sel;
  logic [6:0]        seg_dec;

  assign scan_tick   = (scan_cnt == ScanW'(SCAN_DIV - 1));
  assign frame_start = scan_tick && (digit_idx == 2'd0);
  assign blink_tc    = (blink_cnt == BlinkW'(BLINK_DIV - 1));

  always_comb begin
    sym_sel = code_act[4:0];
    case (digit_idx)
      2'd0: sym_sel = code_act[4:0];
      2'd1: sym_sel = code_act[9:5];
      2'd2: sym_sel = code_act[14:10];
      2'd3: sym_sel = code_act[19:15];
      default: sym_sel = code_act[4:0];
    endcase
  end

  binary_to_segment u_dec (
    .sym (sym_sel),
    .seg (seg_dec)
  );

  // digit_idx wraps 0 -> 3 naturally; started keeps anodes dark until the first tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt  <= '0;
      digit_idx <= 2'd0;
      started   <= 1'b0;
    end else begin
      scan_cnt <= scan_tick ? '0 : scan_cnt + 1'b1;
      if (scan_tick) begin
        digit_idx <= digit_idx - 2'd1;
        started   <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (blink_sync) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (blink_tc) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      code_act     <= CODE_BLANK;
      code_pend    <= CODE_BLANK;
      mask_act     <= 4'b0000;
      mask_pend    <= 4'b0000;
      pend_flag    <= 1'b0;
      disp_updated <= 1'b0;
    end else begin
      disp_updated <= 1'b0;
      if (frame_start) begin
        // A strobe coinciding with the frame start bypasses the pending stage.
        if (code_valid) begin
          code_act     <= code_in;
          mask_act     <= blink_mask;
          disp_updated <= 1'b1;
        end else if (pend_flag) begin
          code_act     <= code_pend;
          mask_act     <= mask_pend;
          disp_updated <= 1'b1;
        end
        pend_flag <= 1'b0;
      end else if (code_valid) begin
        code_pend <= code_in;
        mask_pend <= blink_mask;
        pend_flag <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an  <= 4'b1111;
      seg <= 7'b1111111;
    end else begin
      if (!started || (mask_act[digit_idx] && !blink_phase)) begin
        an <= 4'b1111;
      end else begin
        an <= digit_anode(digit_idx);
      end
      seg <= seg_dec;
    end
  end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed bench for ssd_scan_ctrl with SCAN_DIV=4, BLINK_DIV=32.
module tb_ssd_scan_ctrl;
  import lock_pkg::*;

  logic        clk;
  logic        rst;
  logic [19:0] code_in;
  logic [3:0]  blink_mask;
  logic        code_valid;
  logic        blink_sync;
  logic        disp_updated;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        blink_phase;

  int vectors = 0;
  int miscompares = 0;

  ssd_scan_ctrl #(
    .SCAN_DIV  (4),
    .BLINK_DIV (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .code_in      (code_in),
    .blink_mask   (blink_mask),
    .code_valid   (code_valid),
    .blink_sync   (blink_sync),
    .disp_updated (disp_updated),
    .an           (an),
    .seg          (seg),
    .blink_phase  (blink_phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] exp_an;
    rst        = 1'b0;
    code_in    = 20'h0;
    blink_mask = 4'b0000;
    code_valid = 1'b0;
    blink_sync = 1'b0;
    step(3);
    check("reset_an", {3'b000, an}, 7'h0F);
    check("reset_seg", seg, 7'b1111111);
    check("reset_phase", {6'd0, blink_phase}, 7'd1);
    rst = 1'b1;

    // Scan sequence with blank display; edge numbers count from reset release.
    for (int e = 1; e <= 20; e++) begin
      step(1);
      exp_an = (e < 5) ? 4'b1111 : (4'b1111 ^ (4'b1000 >> ((e - 5) / 4)));
      check("scan_an", {3'b000, an}, {3'b000, exp_an});
      check("scan_seg", seg, 7'b1111111);
      check("scan_upd", {6'd0, disp_updated}, 7'd0);
    end

    // Mid-frame update, applied at frame start edge 36.
    code_valid = 1'b1;
    code_in    = {SYM_C, SYM_L, 5'h05, 5'h0D};
    step(1);
    code_valid = 1'b0;
    check("upd_early", {6'd0, disp_updated}, 7'd0);
    step(14);
    check("upd_before", {6'd0, disp_updated}, 7'd0);
    step(1);
    check("upd_pulse", {6'd0, disp_updated}, 7'd1);
    step(1);
    check("upd_after", {6'd0, disp_updated}, 7'd0);
    check("d3_an", {3'b000, an}, 7'b0000111);
    check("d3_seg_C", seg, 7'b1000110);
    step(4);
    check("d2_an", {3'b000, an}, 7'b0001011);
    check("d2_seg_L", seg, 7'b1000111);
    step(4);
    check("d1_an", {3'b000, an}, 7'b0001101);
    check("d1_seg_5", seg, 7'b0010010);
    step(4);
    check("d0_an", {3'b000, an}, 7'b0001110);
    check("d0_seg_d", seg, 7'b0100001);

    // Two strobes in one frame: latest wins, single pulse at edge 68.
    step(4);
    code_valid = 1'b1;
    code_in    = {4{5'h01}};
    step(1);
    code_valid = 1'b0;
    step(4);
    code_valid = 1'b1;
    code_in    = {4{5'h02}};
    step(1);
    code_valid = 1'b0;
    check("two_none1", {6'd0, disp_updated}, 7'd0);
    step(8);
    check("two_none2", {6'd0, disp_updated}, 7'd0);
    step(1);
    check("two_pulse", {6'd0, disp_updated}, 7'd1);
    step(1);
    check("two_after", {6'd0, disp_updated}, 7'd0);
    check("two_an3", {3'b000, an}, 7'b0000111);
    check("two_seg3", seg, 7'b0100100);
    step(4);
    check("two_seg2", seg, 7'b0100100);
    step(11);
    check("two_single", {6'd0, disp_updated}, 7'd0);

    // Strobe coincident with frame start (cycle ending at edge 100).
    step(15);
    code_valid = 1'b1;
    code_in    = {5'h0E, 5'h0A, SYM_TIRE, 5'h07};
    step(1);
    code_valid = 1'b0;
    check("byp_pulse", {6'd0, disp_updated}, 7'd1);
    step(1);
    check("byp_after", {6'd0, disp_updated}, 7'd0);
    check("byp_an3", {3'b000, an}, 7'b0000111);
    check("byp_seg_E", seg, 7'b0000110);
    step(4);
    check("byp_seg_A", seg, 7'b0001000);
    step(4);
    check("byp_seg_tire", seg, 7'b0111111);
    step(4);
    check("byp_an0", {3'b000, an}, 7'b0001110);
    check("byp_seg_7", seg, 7'b1111000);
    step(3);
    check("byp_no_pend", {6'd0, disp_updated}, 7'd0);

    // Blink on digit3, phase resynced at edge 121.
    code_valid = 1'b1;
    code_in    = {4{5'h08}};
    blink_mask = 4'b1000;
    step(1);
    code_valid = 1'b0;
    blink_mask = 4'b0000;
    step(3);
    blink_sync = 1'b1;
    step(1);
    blink_sync = 1'b0;
    check("sync_phase", {6'd0, blink_phase}, 7'd1);
    step(12);
    check("blk_vis_an", {3'b000, an}, 7'b0000111);
    check("blk_seg8", seg, 7'b0000000);
    step(4);
    check("blk_d2_an", {3'b000, an}, 7'b0001011);
    step(15);
    check("blk_ph_end", {6'd0, blink_phase}, 7'd1);
    step(1);
    check("blk_ph_tog", {6'd0, blink_phase}, 7'd0);
    step(12);
    check("blk_hid_an1", {3'b000, an}, 7'b0001111);
    step(3);
    check("blk_hid_an2", {3'b000, an}, 7'b0001111);
    step(1);
    check("blk_hid_d2", {3'b000, an}, 7'b0001011);
    step(1);
    check("blk_pre_sync", {6'd0, blink_phase}, 7'd0);
    blink_sync = 1'b1;
    step(1);
    blink_sync = 1'b0;
    check("blk_sync", {6'd0, blink_phase}, 7'd1);
    step(10);
    check("blk_resync_an", {3'b000, an}, 7'b0000111);
    step(21);
    check("blk_restart_hold", {6'd0, blink_phase}, 7'd1);
    step(1);
    check("blk_restart_tog", {6'd0, blink_phase}, 7'd0);
    step(10);
    check("blk_hid_an3", {3'b000, an}, 7'b0001111);

    // Async reset with an update pending.
    code_valid = 1'b1;
    code_in    = {4{5'h03}};
    step(1);
    code_valid = 1'b0;
    step(3);
    check("pre_rst_an", {3'b000, an}, 7'b0001011);
    #3;
    rst = 1'b0;
    #1;
    check("arst_an", {3'b000, an}, 7'h0F);
    check("arst_seg", seg, 7'b1111111);
    check("arst_upd", {6'd0, disp_updated}, 7'd0);
    check("arst_phase", {6'd0, blink_phase}, 7'd1);
    step(3);
    rst = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      step(1);
      check("post_upd", {6'd0, disp_updated}, 7'd0);
      check("post_seg", seg, 7'b1111111);
      if (e == 4) check("post_an_dark", {3'b000, an}, 7'h0F);
      if (e == 5) check("post_an_d3", {3'b000, an}, 7'b0000111);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
